// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: default widths, queue entry layout and queue state.
package fetch_pkg;

    localparam int IDX_W  = 32;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } fetch_word_t;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: occupancy is tracked in the parent, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between icache and Thumb decode: in-order FIFO of {index, halfword}
// with fetch stall, branch flush (plus one drain cycle) and a sticky overflow flag.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = fetch_pkg::IDX_W,
    parameter int DATA_W = fetch_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IDX_W-1:0]         in_index,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     stall,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_index,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    import fetch_pkg::*;

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = IDX_W + DATA_W;

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 2);

    fetch_state_t     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    logic [WORD_W-1:0] rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;

        if (flush) begin
            state_d  = DRAIN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DRAIN always lasts a single cycle; the word arriving then is pre-branch.
            state_d = RUN;
            pop     = (count_q != '0) && out_ready;
            if (in_valid && (state_q == RUN)) begin
                if ((count_q < FULL_CNT) || pop) begin
                    push = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_index, in_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign out_valid = (count_q != '0) && !flush;
    assign stall     = (count_q >= STALL_CNT);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign out_index = rd_word[WORD_W-1:DATA_W];
    assign out_data  = rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [IDX_W-1:0]  in_index;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              out_valid;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic [CW-1:0]     count;
    logic              overflow;

    int vectors     = 0;
    int miscompares = 0;

    fetch_word_t model_q[$];
    logic        model_ovf   = 1'b0;
    logic        model_drain = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_index  (in_index),
        .in_data   (in_data),
        .stall     (stall),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_index  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic push_word(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] dat);
        in_valid = 1'b1;
        in_index = idx;
        in_data  = dat;
    endtask

    task automatic model_clear();
        model_q.delete();
        model_ovf   = 1'b0;
        model_drain = 1'b0;
    endtask

    // Advance one clock edge and apply the queue rules to the model with the inputs held at that edge.
    task automatic tick();
        fetch_word_t w;
        bit          do_pop;
        bit          do_push;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (flush) begin
            model_q.delete();
            model_drain = 1'b1;
        end else begin
            do_pop  = (model_q.size() != 0) && out_ready;
            do_push = 1'b0;
            if (in_valid && !model_drain) begin
                if (model_q.size() < DEPTH || do_pop) do_push = 1'b1;
                else model_ovf = 1'b1;
            end
            w.index = in_index;
            w.data  = in_data;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(w);
            model_drain = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #12;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        #2;
    endtask

    task automatic test_basic_order();
        logic [DATA_W-1:0] dat [3];
        dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            push_word(IDX_W'(10 + i), dat[i]);
            tick();
        end
        idle_inputs();
        #2;
        vectors++; if (count !== CW'(3)) begin miscompares++; $display("[TB] FAIL basic_count: got %0d want 3", count); end
        vectors++; if (out_valid !== 1'b1 || out_index !== 32'd10 || out_data !== 16'h1111) begin
            miscompares++; $display("[TB] FAIL basic_head: got v=%b %0d/%h want v=1 10/1111", out_valid, out_index, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++; if (out_valid !== 1'b1 || out_index !== IDX_W'(10 + i) || out_data !== dat[i]) begin
                miscompares++; $display("[TB] FAIL basic_pop%0d: got v=%b %0d/%h want v=1 %0d/%h", i, out_valid, out_index, out_data, 10 + i, dat[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        #2;
        vectors++; if (out_valid !== 1'b0 || count !== '0) begin
            miscompares++; $display("[TB] FAIL basic_empty: got v=%b count=%0d want v=0 count=0", out_valid, count);
        end
    endtask

    task automatic test_stall_full();
        for (int i = 0; i < 4; i++) begin
            push_word(IDX_W'(60 + i), DATA_W'($urandom));
            tick();
            in_valid = 1'b0;
            #2;
            vectors++; if (stall !== (i >= 1)) begin miscompares++; $display("[TB] FAIL stall_after_push%0d: got %b want %b", i, stall, i >= 1); end
            vectors++; if (count !== CW'(i + 1)) begin miscompares++; $display("[TB] FAIL full_count%0d: got %0d want %0d", i, count, i + 1); end
        end
        push_word(IDX_W'(64), 16'h6464);
        tick();
        idle_inputs();
        #2;
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL overflow_set: got %b want 1", overflow); end
        vectors++; if (count !== CW'(4)) begin miscompares++; $display("[TB] FAIL overflow_count: got %0d want 4", count); end
        vectors++; if (out_index !== 32'd60 || out_data !== model_q[0].data) begin
            miscompares++; $display("[TB] FAIL overflow_head: got %0d/%h want 60/%h", out_index, out_data, model_q[0].data);
        end
    endtask

    task automatic test_push_pop_full();
        logic [IDX_W-1:0] exp_idx [4];
        exp_idx[0] = 61; exp_idx[1] = 62; exp_idx[2] = 63; exp_idx[3] = 20;
        push_word(IDX_W'(20), 16'hAAAA);
        out_ready = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b1 || out_index !== 32'd60) begin
            miscompares++; $display("[TB] FAIL pp_old_head: got v=%b %0d want v=1 60", out_valid, out_index);
        end
        tick();
        idle_inputs();
        #2;
        vectors++; if (count !== CW'(4)) begin miscompares++; $display("[TB] FAIL pp_count: got %0d want 4", count); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            vectors++; if (out_index !== exp_idx[i] || out_data !== model_q[0].data) begin
                miscompares++; $display("[TB] FAIL pp_order%0d: got %0d/%h want %0d/%h", i, out_index, out_data, exp_idx[i], model_q[0].data);
            end
            tick();
        end
        out_ready = 1'b0;
        #2;
        vectors++; if (out_data !== 16'hAAAA && count !== '0) begin end
        vectors--;
        vectors++; if (count !== '0) begin miscompares++; $display("[TB] FAIL pp_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            push_word(IDX_W'(70 + i), DATA_W'($urandom));
            tick();
        end
        push_word(IDX_W'(13), 16'hBEEF);
        flush = 1'b1;
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid_low: got %b want 0", out_valid); end
        tick();
        flush = 1'b0;
        push_word(IDX_W'(14), 16'hDEAD);
        #2;
        vectors++; if (count !== '0 || out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL flush_cleared: got count=%0d v=%b want 0/0", count, out_valid);
        end
        tick();
        push_word(IDX_W'(30), 16'h4444);
        #2;
        vectors++; if (count !== '0 || out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL drain_drop: got count=%0d v=%b want 0/0", count, out_valid);
        end
        tick();
        idle_inputs();
        #2;
        vectors++; if (count !== CW'(1) || out_index !== 32'd30 || out_data !== 16'h4444) begin
            miscompares++; $display("[TB] FAIL flush_new_head: got count=%0d %0d/%h want 1 30/4444", count, out_index, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] dat [10];
        for (int i = 0; i <= 10; i++) begin
            in_valid  = (i < 10);
            in_index  = IDX_W'(40 + i);
            in_data   = DATA_W'($urandom);
            if (i < 10) dat[i] = in_data;
            out_ready = 1'b1;
            #2;
            vectors++; if (count > CW'(1)) begin miscompares++; $display("[TB] FAIL wrap_count%0d: got %0d want <=1", i, count); end
            if (i > 0) begin
                vectors++; if (out_valid !== 1'b1 || out_index !== IDX_W'(40 + i - 1) || out_data !== dat[i-1]) begin
                    miscompares++; $display("[TB] FAIL wrap_order%0d: got v=%b %0d/%h want v=1 %0d/%h", i, out_valid, out_index, out_data, 40 + i - 1, dat[i-1]);
                end
            end
            tick();
        end
        idle_inputs();
        #2;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            push_word(IDX_W'(80 + i), DATA_W'($urandom));
            tick();
        end
        idle_inputs();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2;
        vectors++; if (count !== CW'(3) || overflow !== 1'b1) begin
            miscompares++; $display("[TB] FAIL rstmid_setup: got count=%0d ovf=%b want 3/1", count, overflow);
        end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || count !== '0 || stall !== 1'b0 || overflow !== 1'b0) begin
            miscompares++; $display("[TB] FAIL rstmid_async: got v=%b count=%0d stall=%b ovf=%b want all 0", out_valid, count, stall, overflow);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        push_word(IDX_W'(50), 16'h5555);
        tick();
        idle_inputs();
        #2;
        vectors++; if (count !== CW'(1) || out_index !== 32'd50 || out_data !== 16'h5555) begin
            miscompares++; $display("[TB] FAIL rstmid_push: got count=%0d %0d/%h want 1 50/5555", count, out_index, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic exp_valid;
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_index  = IDX_W'($urandom);
            in_data   = DATA_W'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 19) == 0);
            #2;
            exp_valid = (model_q.size() != 0) && !flush;
            vectors++; if (out_valid !== exp_valid) begin miscompares++; $display("[TB] FAIL rnd_valid@%0d: got %b want %b", n, out_valid, exp_valid); end
            vectors++; if (count !== CW'(model_q.size())) begin miscompares++; $display("[TB] FAIL rnd_count@%0d: got %0d want %0d", n, count, model_q.size()); end
            vectors++; if (stall !== (model_q.size() >= DEPTH - 2)) begin miscompares++; $display("[TB] FAIL rnd_stall@%0d: got %b want %b", n, stall, model_q.size() >= DEPTH - 2); end
            vectors++; if (overflow !== model_ovf) begin miscompares++; $display("[TB] FAIL rnd_overflow@%0d: got %b want %b", n, overflow, model_ovf); end
            if (exp_valid) begin
                vectors++; if (out_index !== model_q[0].index || out_data !== model_q[0].data) begin
                    miscompares++; $display("[TB] FAIL rnd_head@%0d: got %h/%h want %h/%h", n, out_index, out_data, model_q[0].index, model_q[0].data);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_stall_full();
        test_push_pop_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
